// File: rtl/snake_engine.sv
// Single-snake game engine: grid-cell segment store, sequential self-collision scan, 2-stage cell query.
// Build macro SNAKE_WRAP_WALLS_EN: grid edges wrap around instead of ending the game.
module snake_engine #(
  parameter int GRID_W   = 17,
  parameter int GRID_H   = 16,
  parameter int CW       = 5,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3,
  parameter int INIT_X   = 3,
  parameter int INIT_Y   = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic [3:0]    dir_req,
  input  logic [CW-1:0] apple_x,
  input  logic [CW-1:0] apple_y,
  input  logic [CW-1:0] q_x,
  input  logic [CW-1:0] q_y,
  output logic          q_head,
  output logic          q_body,
  output logic [CW-1:0] head_x,
  output logic [CW-1:0] head_y,
  output logic [CW:0]   length,
  output logic          apple_eaten,
  output logic          busy,
  output logic          game_over,
  output logic [1:0]    state_dbg
);

  localparam int IW = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1;
  localparam logic [CW-1:0] X_MAX    = CW'(GRID_W - 1);
  localparam logic [CW-1:0] Y_MAX    = CW'(GRID_H - 1);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [CW:0]   LEN_MAX  = (CW+1)'(MAX_LEN);
  localparam logic [CW:0]   LEN_INIT = (CW+1)'(INIT_LEN);
  localparam logic [CW:0]   ONE_L    = (CW+1)'(1);
  localparam logic [CW:0]   TWO_L    = (CW+1)'(2);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_MOVE, S_OVER} state_t;
  // Opposite directions differ only in bit 0.
  typedef enum logic [1:0] {D_RIGHT, D_LEFT, D_UP, D_DOWN} dir_t;

  state_t        state, state_n;
  dir_t          dir, pending, step_dir, req_dir, commit_val;
  logic [1:0]    opp_dir;
  logic          req_valid, req_ok;
  logic [CW-1:0] seg_x [MAX_LEN];
  logic [CW-1:0] seg_y [MAX_LEN];
  logic [CW-1:0] nh_x, nh_y, nh_x_r, nh_y_r;
  logic          wall_hit, eat_now, eat_r;
  logic [IW-1:0] idx;
  logic [CW:0]   scan_limit;
  logic          seg_hit, idx_at_limit;
  logic          load_step, idx_inc, do_move, commit_dir;
  logic [CW-1:0] q1_x, q1_y;
  logic          hit_head, hit_body;

  // Direction request decode: right > left > up > down.
  always_comb begin
    req_valid = |dir_req;
    req_dir   = D_RIGHT;
    if (dir_req[1])      req_dir = D_RIGHT;
    else if (dir_req[0]) req_dir = D_LEFT;
    else if (dir_req[2]) req_dir = D_UP;
    else if (dir_req[3]) req_dir = D_DOWN;
  end

  assign opp_dir = dir ^ 2'b01;
  assign req_ok  = req_valid && (req_dir != dir_t'(opp_dir));

  // Next head cell from the current head and the pending direction.
  always_comb begin
    nh_x     = seg_x[0];
    nh_y     = seg_y[0];
    wall_hit = 1'b0;
    case (pending)
      D_RIGHT: begin
`ifdef SNAKE_WRAP_WALLS_EN
        nh_x = (seg_x[0] == X_MAX) ? '0 : seg_x[0] + ONE_C;
`else
        wall_hit = (seg_x[0] == X_MAX);
        nh_x     = seg_x[0] + ONE_C;
`endif
      end
      D_LEFT: begin
`ifdef SNAKE_WRAP_WALLS_EN
        nh_x = (seg_x[0] == '0) ? X_MAX : seg_x[0] - ONE_C;
`else
        wall_hit = (seg_x[0] == '0);
        nh_x     = seg_x[0] - ONE_C;
`endif
      end
      D_UP: begin
`ifdef SNAKE_WRAP_WALLS_EN
        nh_y = (seg_y[0] == '0) ? Y_MAX : seg_y[0] - ONE_C;
`else
        wall_hit = (seg_y[0] == '0);
        nh_y     = seg_y[0] - ONE_C;
`endif
      end
      default: begin
`ifdef SNAKE_WRAP_WALLS_EN
        nh_y = (seg_y[0] == Y_MAX) ? '0 : seg_y[0] + ONE_C;
`else
        wall_hit = (seg_y[0] == Y_MAX);
        nh_y     = seg_y[0] + ONE_C;
`endif
      end
    endcase
  end

  assign eat_now      = (nh_x == apple_x) && (nh_y == apple_y);
  // Without eating the tail vacates during the move, so it is excluded from the scan.
  assign scan_limit   = eat_r ? (length - ONE_L) : (length - TWO_L);
  assign seg_hit      = (seg_x[idx] == nh_x_r) && (seg_y[idx] == nh_y_r);
  assign idx_at_limit = ((CW+1)'(idx) >= scan_limit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // tick is a fire-and-forget pulse: taken only in IDLE, silently dropped while busy.
  always_comb begin
    state_n    = state;
    load_step  = 1'b0;
    idx_inc    = 1'b0;
    do_move    = 1'b0;
    commit_dir = 1'b0;
    commit_val = step_dir;
    case (state)
      S_IDLE: begin
        if (tick) begin
          if (wall_hit) begin
            state_n = S_OVER;
          end else begin
            load_step = 1'b1;
            if (!eat_now && (length == TWO_L)) begin
              state_n    = S_MOVE;
              commit_dir = 1'b1;
              commit_val = pending;
            end else begin
              state_n = S_CHECK;
            end
          end
        end
      end
      S_CHECK: begin
        if (seg_hit) begin
          state_n = S_OVER;
        end else if (idx_at_limit) begin
          state_n    = S_MOVE;
          commit_dir = 1'b1;
        end else begin
          idx_inc = 1'b1;
        end
      end
      S_MOVE: begin
        do_move = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_OVER;
    endcase
  end

  // The committed direction follows the step actually taken, not later pending edits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir      <= D_RIGHT;
      pending  <= D_RIGHT;
      step_dir <= D_RIGHT;
      nh_x_r   <= '0;
      nh_y_r   <= '0;
      eat_r    <= 1'b0;
      idx      <= IW'(1);
      length   <= LEN_INIT;
      for (int k = 0; k < MAX_LEN; k++) begin
        seg_x[k] <= (k < INIT_LEN) ? CW'(INIT_X - k) : '0;
        seg_y[k] <= (k < INIT_LEN) ? CW'(INIT_Y) : '0;
      end
    end else begin
      if (req_ok)     pending <= req_dir;
      if (commit_dir) dir     <= commit_val;
      if (load_step) begin
        nh_x_r   <= nh_x;
        nh_y_r   <= nh_y;
        eat_r    <= eat_now;
        step_dir <= pending;
        idx      <= IW'(1);
      end else if (idx_inc) begin
        idx <= idx + IW'(1);
      end
      if (do_move) begin
        for (int k = MAX_LEN - 1; k > 0; k--) begin
          seg_x[k] <= seg_x[k-1];
          seg_y[k] <= seg_y[k-1];
        end
        seg_x[0] <= nh_x_r;
        seg_y[0] <= nh_y_r;
        if (eat_r && (length < LEN_MAX)) length <= length + ONE_L;
      end
    end
  end

  // Query stage 2 compares the registered cell against the live segment store.
  always_comb begin
    hit_head = (seg_x[0] == q1_x) && (seg_y[0] == q1_y);
    hit_body = 1'b0;
    for (int k = 1; k < MAX_LEN; k++) begin
      if (((CW+1)'(k) < length) && (seg_x[k] == q1_x) && (seg_y[k] == q1_y)) hit_body = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q1_x   <= '0;
      q1_y   <= '0;
      q_head <= 1'b0;
      q_body <= 1'b0;
    end else begin
      q1_x   <= q_x;
      q1_y   <= q_y;
      q_head <= hit_head;
      q_body <= hit_body;
    end
  end

  assign head_x      = seg_x[0];
  assign head_y      = seg_y[0];
  assign apple_eaten = (state == S_MOVE) && eat_r;
  assign busy        = (state != S_IDLE);
  assign game_over   = (state == S_OVER);
  assign state_dbg   = state;

endmodule

// File: tb/tb_snake_engine.sv
// Self-checking bench for snake_engine: step scoreboard plus direct query/status checks.
module tb_snake_engine;

  localparam int CW = 5;
  localparam int W  = 2 + (CW + 1) + CW + CW;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_OVER  = 2'd3;
  localparam logic [3:0] DIR_LEFT  = 4'b0001;
  localparam logic [3:0] DIR_RIGHT = 4'b0010;
  localparam logic [3:0] DIR_UP    = 4'b0100;
  localparam logic [3:0] DIR_DOWN  = 4'b1000;

  logic          clk     = 1'b0;
  logic          reset   = 1'b1;
  logic          tick    = 1'b0;
  logic [3:0]    dir_req = 4'b0000;
  logic [CW-1:0] apple_x = 5'd0;
  logic [CW-1:0] apple_y = 5'd15;
  logic [CW-1:0] q_x     = 5'd0;
  logic [CW-1:0] q_y     = 5'd0;
  logic          q_head, q_body, apple_eaten, busy, game_over;
  logic [CW-1:0] head_x, head_y;
  logic [CW:0]   length;
  logic [1:0]    state_dbg;

  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  snake_engine dut (
    .clk(clk), .reset(reset), .tick(tick), .dir_req(dir_req),
    .apple_x(apple_x), .apple_y(apple_y), .q_x(q_x), .q_y(q_y),
    .q_head(q_head), .q_body(q_body), .head_x(head_x), .head_y(head_y),
    .length(length), .apple_eaten(apple_eaten), .busy(busy),
    .game_over(game_over), .state_dbg(state_dbg)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic apply_reset();
    reset   = 1'b1;
    tick    = 1'b0;
    dir_req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_exp(input int eats, input int len, input int hx, input int hy);
    exp_q.push_back({2'(eats), (CW+1)'(len), CW'(hy), CW'(hx)});
  endtask

  // One tick, then wait (bounded) for IDLE or OVER; obs = {eat pulses, length, head_y, head_x}.
  task automatic do_step(output logic [W-1:0] obs);
    int eat_cnt;
    int c;
    eat_cnt = 0;
    c = 0;
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    if (apple_eaten) eat_cnt++;
    while (busy && !game_over && c < 64) begin
      @(negedge clk);
      c++;
      if (apple_eaten) eat_cnt++;
    end
    if (busy && !game_over) obs = 'x;
    else obs = {2'((eat_cnt > 3) ? 3 : eat_cnt), length, head_y, head_x};
  endtask

  task automatic query(input int x, input int y, output logic [1:0] hb);
    @(negedge clk);
    q_x = CW'(x);
    q_y = CW'(y);
    repeat (2) @(negedge clk);
    hb = {q_head, q_body};
  endtask

  // Scenarios
  task automatic test_reset();
    logic [1:0] hb;
    q_x = 5'd3;
    q_y = 5'd1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({q_head, q_body} !== 2'b00) begin
      failures++;
      $display("FAIL reset_query_held: got %b want 00", {q_head, q_body});
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({head_x, head_y, length, busy, game_over, apple_eaten, state_dbg} !==
        {5'd3, 5'd1, 6'd3, 1'b0, 1'b0, 1'b0, ST_IDLE}) begin
      failures++;
      $display("FAIL reset_values: head=(%0d,%0d) len=%0d busy=%b over=%b eat=%b st=%0d", head_x, head_y,
               length, busy, game_over, apple_eaten, state_dbg);
    end
    query(3, 1, hb);
    checks++;
    if (hb !== 2'b10) begin
      failures++;
      $display("FAIL reset_query_head: got %b want 10", hb);
    end
  endtask

  task automatic test_basic_move();
    logic [W-1:0] obs, exp;
    logic [1:0] hb;
    int qx[4] = '{4, 5, 2, 3};
    logic [1:0] qe[4] = '{2'b01, 2'b10, 2'b00, 2'b01};
    for (int s = 0; s < 2; s++) begin
      push_exp(0, 3, 4 + s, 1);
      do_step(obs);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL basic_step%0d: got %h want %h", s, obs, exp);
      end
    end
    for (int i = 0; i < 4; i++) begin
      query(qx[i], 1, hb);
      checks++;
      if (hb !== qe[i]) begin
        failures++;
        $display("FAIL basic_query_x%0d: got %b want %b", qx[i], hb, qe[i]);
      end
    end
  endtask

  task automatic test_direction();
    logic [W-1:0] obs, exp;
    logic [3:0] req[5] = '{DIR_LEFT, DIR_RIGHT, DIR_DOWN, DIR_UP, 4'b1011};
    int ex[5] = '{6, 7, 7, 7, 8};
    int ey[5] = '{1, 1, 2, 3, 3};
    for (int s = 0; s < 5; s++) begin
      if (s == 1) begin
        dir_req = DIR_DOWN;
        repeat (2) @(negedge clk);
      end
      dir_req = req[s];
      push_exp(0, 3, ex[s], ey[s]);
      do_step(obs);
      dir_req = '0;
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL dir_step%0d: got %h want %h", s, obs, exp);
      end
    end
  endtask

  task automatic test_eat();
    logic [W-1:0] obs, exp;
    logic [1:0] hb;
    apply_reset();
    for (int x = 4; x <= 16; x++) begin
      apple_x = CW'(x);
      apple_y = 5'd1;
      push_exp(1, x, x, 1);
      do_step(obs);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL eat_grow_x%0d: got %h want %h", x, obs, exp);
      end
    end
    for (int y = 2; y <= 3; y++) begin
      apple_x = 5'd16;
      apple_y = CW'(y);
      dir_req = DIR_DOWN;
      push_exp(1, 16, 16, y);
      do_step(obs);
      dir_req = '0;
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL eat_saturate_y%0d: got %h want %h", y, obs, exp);
      end
    end
    apple_x = 5'd0;
    apple_y = 5'd15;
    query(3, 1, hb);
    checks++;
    if (hb !== 2'b01) begin
      failures++;
      $display("FAIL eat_max_last_seg: got %b want 01", hb);
    end
    query(2, 1, hb);
    checks++;
    if (hb !== 2'b00) begin
      failures++;
      $display("FAIL eat_max_tail_dropped: got %b want 00", hb);
    end
  endtask

  task automatic test_wall();
    logic [W-1:0] obs, exp;
    logic [1:0] hb;
    apply_reset();
    for (int x = 4; x <= 16; x++) begin
      push_exp(0, 3, x, 1);
      do_step(obs);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL wall_run_x%0d: got %h want %h", x, obs, exp);
      end
    end
`ifdef SNAKE_WRAP_WALLS_EN
    push_exp(0, 3, 0, 1);
    push_exp(0, 3, 1, 1);
    for (int s = 0; s < 2; s++) begin
      do_step(obs);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp || game_over !== 1'b0) begin
        failures++;
        $display("FAIL wall_wrap%0d: got %h over=%b want %h over=0", s, obs, game_over, exp);
      end
    end
    query(16, 1, hb);
    checks++;
    if (hb !== 2'b01) begin
      failures++;
      $display("FAIL wall_wrap_query: got %b want 01", hb);
    end
`else
    push_exp(0, 3, 16, 1);
    do_step(obs);
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp || {game_over, busy, state_dbg} !== {1'b1, 1'b1, ST_OVER}) begin
      failures++;
      $display("FAIL wall_hit: got %h over=%b busy=%b st=%0d want %h over=1 busy=1 st=3", obs, game_over,
               busy, state_dbg, exp);
    end
    dir_req = DIR_UP;
    push_exp(0, 3, 16, 1);
    do_step(obs);
    dir_req = '0;
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp || game_over !== 1'b1) begin
      failures++;
      $display("FAIL wall_frozen: got %h over=%b want %h over=1", obs, game_over, exp);
    end
    query(14, 1, hb);
    checks++;
    if (hb !== 2'b01) begin
      failures++;
      $display("FAIL wall_frozen_body: got %b want 01", hb);
    end
`endif
  endtask

  task automatic test_self_collision();
    logic [W-1:0] obs, exp;
    logic [1:0] hb;
    logic [3:0] req[5] = '{4'b0000, 4'b0000, DIR_DOWN, DIR_LEFT, DIR_UP};
    int ax[5] = '{4, 5, 0, 0, 0};
    int ay[5] = '{1, 1, 15, 15, 15};
    int ee[5] = '{1, 1, 0, 0, 0};
    int el[5] = '{4, 5, 5, 5, 5};
    int ex[5] = '{4, 5, 5, 4, 4};
    int ey[5] = '{1, 1, 2, 2, 2};
    apply_reset();
    for (int s = 0; s < 5; s++) begin
      apple_x = CW'(ax[s]);
      apple_y = CW'(ay[s]);
      dir_req = req[s];
      push_exp(ee[s], el[s], ex[s], ey[s]);
      do_step(obs);
      dir_req = '0;
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL uturn_step%0d: got %h want %h", s, obs, exp);
      end
    end
    checks++;
    if (game_over !== 1'b1) begin
      failures++;
      $display("FAIL uturn_over: got %b want 1", game_over);
    end
    // Chase the vacating tail tip at length 4.
    apply_reset();
    for (int s = 0; s < 4; s++) begin
      apple_x = (s == 0) ? 5'd4 : 5'd0;
      apple_y = (s == 0) ? 5'd1 : 5'd15;
      dir_req = (s == 1) ? DIR_DOWN : (s == 2) ? DIR_LEFT : (s == 3) ? DIR_UP : 4'b0000;
      push_exp((s == 0) ? 1 : 0, 4, (s < 2) ? 4 : 3, (s == 0 || s == 3) ? 1 : 2);
      do_step(obs);
      dir_req = '0;
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp || game_over !== 1'b0) begin
        failures++;
        $display("FAIL tail_chase_step%0d: got %h over=%b want %h over=0", s, obs, game_over, exp);
      end
    end
    query(4, 1, hb);
    checks++;
    if (hb !== 2'b01) begin
      failures++;
      $display("FAIL tail_chase_query: got %b want 01", hb);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] obs, exp;
    logic [1:0] hb;
    int c;
    apply_reset();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_busy: got %b want 1", busy);
    end
    @(negedge clk);
    tick = 1'b0;
    c = 0;
    while (busy && c < 64) begin
      @(negedge clk);
      c++;
    end
    repeat (4) @(negedge clk);
    push_exp(0, 3, 4, 1);
    obs = busy ? 'x : {2'b00, length, head_y, head_x};
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL b2b_tick_dropped: got %h want %h", obs, exp);
    end
    // Reset while the collision scan is in progress.
    query(4, 1, hb);
    checks++;
    if (hb !== 2'b10) begin
      failures++;
      $display("FAIL midcheck_pre_query: got %b want 10", hb);
    end
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    checks++;
    if (state_dbg !== ST_CHECK) begin
      failures++;
      $display("FAIL midcheck_state: got %0d want 1", state_dbg);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({q_head, q_body, busy, head_x, length} !== {1'b0, 1'b0, 1'b0, 5'd3, 6'd3}) begin
      failures++;
      $display("FAIL midcheck_in_reset: qh=%b qb=%b busy=%b hx=%0d len=%0d", q_head, q_body, busy, head_x,
               length);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({head_x, head_y, length, busy, game_over, apple_eaten, q_head, q_body} !==
        {5'd3, 5'd1, 6'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL midcheck_after_reset: head=(%0d,%0d) len=%0d busy=%b over=%b eat=%b q=%b%b", head_x,
               head_y, length, busy, game_over, apple_eaten, q_head, q_body);
    end
    query(2, 1, hb);
    checks++;
    if (hb !== 2'b01) begin
      failures++;
      $display("FAIL midcheck_query_body: got %b want 01", hb);
    end
    push_exp(0, 3, 4, 1);
    do_step(obs);
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL midcheck_step_after: got %h want %h", obs, exp);
    end
  endtask

  initial begin
    test_reset();
    test_basic_move();
    test_direction();
    test_eat();
    test_wall();
    test_self_collision();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
